// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum accumulator slice.
// Holds the accumulator FSM state encoding and the width of the upstream adder result.
// No logic; imported by sum_accumulator and sat_add.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Upstream 4-bit adder result: {carry_out, sum[3:0]}.
    localparam int SUM_W = 5;

endpackage

// File: rtl/sat_add.sv
// Saturating add of an unsigned W-bit running total and an unsigned adder result.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: a = running total, b = new sample, y = clamped sum, sat = true sum overflowed W bits.
module sat_add
    import sum_acc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]     a,
    input  logic [SUM_W-1:0] b,
    output logic [W-1:0]     y,
    output logic             sat
);

    // One extra bit of headroom: its MSB is the overflow indicator.
    logic [W:0] wide;

    assign wide = {1'b0, a} + {{(W + 1 - SUM_W){1'b0}}, b};
    assign sat  = wide[W];
    assign y    = wide[W] ? {W{1'b1}} : wide[W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a frame of len 5-bit adder results into a saturating ACC_W-bit total with sticky overflow.
// Latency: out_valid rises on the edge after the last accepted sample of a frame.
// Backpressure: in_ready drops while a finished frame waits in DONE; the frame is held until out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data sample stream; len frame length
//        (0 means 1, latched on first sample); out_valid/out_ready/out_sum/out_ovf result; busy.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_data,
    input  logic [CNT_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    acc_state_t       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] len_q, len_q_nxt;
    logic             load_out;

    logic             accept;
    logic             complete;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] add_y;
    logic             add_sat;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc),
        .b   (in_data),
        .y   (add_y),
        .sat (add_sat)
    );

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = !rst && (state != DONE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign complete = out_valid && out_ready;
    assign len_eff  = (len == '0) ? CNT_W'(1) : len;
    assign cnt_inc  = cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        cnt_nxt   = cnt;
        len_q_nxt = len_q;
        load_out  = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    len_q_nxt = len_eff;
                    acc_nxt   = ACC_W'(in_data);
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = CNT_W'(1);
                    if (len_eff == CNT_W'(1)) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = add_y;
                    ovf_nxt = ovf | add_sat;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (complete) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_q_nxt;
            // The output registers capture the total including the final sample.
            if (load_out) begin
                out_valid <= 1'b1;
                out_sum   <= acc_nxt;
                out_ovf   <= ovf_nxt;
            end else if (complete) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic [3:0] len;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int samp [16];

    sum_accumulator #(.ACC_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Send one frame of samp[0..eff-1]; optional random gaps and mid-frame len changes.
    // Then hold out_ready low for 'hold' cycles (offering junk samples) and complete.
    task automatic do_frame(input int l, input int hold, input bit rnd);
        int eff;
        int total;
        int exp_sum;
        int exp_ovf;
        eff   = (l == 0) ? 1 : l;
        total = 0;
        for (int i = 0; i < eff; i++) begin
            if (rnd && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                tick();
                check("gap_no_out", out_valid, 0);
            end
            len      = (i == 0 || !rnd) ? 4'(l) : 4'($urandom_range(0, 15));
            in_valid = 1'b1;
            in_data  = 5'(samp[i]);
            check("in_ready_accum", in_ready, 1);
            total += samp[i];
            tick();
        end
        in_valid = 1'b0;
        exp_sum  = (total > 255) ? 255 : total;
        exp_ovf  = (total > 255) ? 1 : 0;
        check("out_valid_rise", out_valid, 1);
        check("out_sum", out_sum, exp_sum);
        check("out_ovf", out_ovf, exp_ovf);
        check("in_ready_done", in_ready, 0);
        check("busy_done", busy, 1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 5'($urandom_range(0, 31));
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, exp_sum);
            check("hold_ovf", out_ovf, exp_ovf);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_in_ready", in_ready, 1);
        check("post_sum_kept", out_sum, exp_sum);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        len       = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        tick();
        tick();
        check("rst_in_ready2", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // len=3: 5+10+17 = 32
        samp[0] = 5; samp[1] = 10; samp[2] = 17;
        do_frame(3, 0, 1'b0);

        // len=15 of 31: saturates, sticky ovf
        for (int i = 0; i < 15; i++) samp[i] = 31;
        do_frame(15, 0, 1'b0);

        // len=0 behaves as len=1
        samp[0] = 7;
        do_frame(0, 0, 1'b0);
        do_frame(1, 0, 1'b0);

        // Backpressure held for 5 cycles, then a short frame.
        samp[0] = 3; samp[1] = 4;
        do_frame(2, 5, 1'b0);
        samp[0] = 9;
        do_frame(1, 0, 1'b0);

        // Abort mid-frame with reset.
        len      = 4'd4;
        in_valid = 1'b1;
        in_data  = 5'd20;
        tick();
        in_data  = 5'd30;
        tick();
        in_valid = 1'b0;
        check("abort_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready_rst", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy_clr", busy, 0);
        check("abort_sum_clr", out_sum, 0);
        samp[0] = 2;
        do_frame(1, 0, 1'b0);

        // Randomized frames with gaps, len churn and backpressure.
        for (int f = 0; f < 40; f++) begin
            int l;
            l = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) samp[i] = $urandom_range(0, 31);
            do_frame(l, $urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
